pe_relay_fifo: RTL and testbench



---
 rtl/pe_relay_pkg.sv | 32 +++
 rtl/pe_relay_chan_fifo.sv | 72 +++++++
 rtl/pe_relay_fifo.sv | 104 ++++++++++
 tb/tb_pe_relay_fifo.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_relay_pkg.sv
// pe_relay_pkg
//   Shared types and helpers for the relay PE.
//   - relay_state_e : FSM shared by all channels of one PE site.
//   - ptr_w / cnt_w : derive FIFO pointer and occupancy counter widths
//                     from the FIFO depth.
//   - slice_lo      : low bit index of element idx in a packed bus of
//                     equal-width elements.
package pe_relay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } relay_state_e;

  localparam int DEF_FIFO_DEPTH = 4;

  // Pointer width: depth is a power of two, so pointers wrap by overflow.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Counter width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/pe_relay_chan_fifo.sv
// pe_relay_chan_fifo
//   One relayed link: a FIFO_DEPTH-entry circular buffer with valid/ready
//   on both sides.
// Ports:
//   clk, reset      clock, synchronous active-high reset (pointers/count only)
//   push            upstream valid; accepted when ready is high
//   pop             downstream ready; takes effect when valid is high
//   run_en, drain   FSM qualifiers from the top (state RUN / state DRAIN)
//   wr_data         incoming word
//   count           current number of stored words
//   ready           space available and not draining
//   valid           word available and forwarding enabled
//   data            head-of-queue word, straight from storage
module pe_relay_chan_fifo
  import pe_relay_pkg::*;
#(
  parameter int CH_WIDTH   = 130,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  logic                             pop,
  input  logic                             run_en,
  input  logic                             drain,
  input  logic [CH_WIDTH-1:0]              wr_data,
  output logic [cnt_w(FIFO_DEPTH)-1:0]     count,
  output logic                             ready,
  output logic                             valid,
  output logic [CH_WIDTH-1:0]              data
);

  localparam int PTR_W = ptr_w(FIFO_DEPTH);
  localparam int CNT_W = cnt_w(FIFO_DEPTH);

  logic [CH_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                push_fire;
  logic                pop_fire;

  // Handshake qualifiers depend only on registered count and FSM state,
  // so neither ready nor valid has a combinational path from the other side.
  assign ready     = (count != CNT_W'(FIFO_DEPTH)) && !drain;
  assign valid     = (count != '0) && (run_en || drain);
  assign push_fire = push && ready;
  assign pop_fire  = pop && valid;
  assign data      = mem[rd_ptr];

  // Control registers: pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_fire, pop_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Data storage: not reset, contents are only observed while count != 0.
  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/pe_relay_fifo.sv
// pe_relay_fifo
//   PE that relays NUM_CH independent valid/ready links through
//   small FIFOs so neighbouring PEs stay live and lossless.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   ap_start        level: 1 forwards data, 0 holds outputs (intake continues)
//   flush           single-cycle request to drain every channel
//   in_data/in_valid/in_ready      upstream links, channel k at slice k
//   out_data/out_valid/out_ready   downstream links, same layout
//   occupancy       per-channel word count, CNT_BITS per channel
//   flush_done      one-cycle pulse when the drain completes
module pe_relay_fifo
  import pe_relay_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int CH_WIDTH   = 130,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  // Derived; leave at its default.
  parameter int CNT_BITS   = cnt_w(FIFO_DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ap_start,
  input  logic                         flush,
  input  logic [NUM_CH*CH_WIDTH-1:0]   in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  output logic [NUM_CH*CH_WIDTH-1:0]   out_data,
  output logic [NUM_CH-1:0]            out_valid,
  input  logic [NUM_CH-1:0]            out_ready,
  output logic [NUM_CH*CNT_BITS-1:0]   occupancy,
  output logic                         flush_done
);

  relay_state_e      state;
  relay_state_e      state_nxt;
  logic [NUM_CH-1:0] chan_empty;
  logic              all_empty;
  logic              run_en;
  logic              drain;

  assign all_empty = &chan_empty;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: flush outranks ap_start; DRAIN ignores both.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (flush)         state_nxt = DRAIN;
        else if (ap_start) state_nxt = RUN;
      end
      RUN: begin
        if (flush)          state_nxt = DRAIN;
        else if (!ap_start) state_nxt = IDLE;
      end
      DRAIN: begin
        if (all_empty) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: flush_done marks the DRAIN->IDLE transition cycle, which
  // lasts exactly one cycle because DRAIN always leaves once empty.
  always_comb begin
    run_en     = (state == RUN);
    drain      = (state == DRAIN);
    flush_done = (state == DRAIN) && all_empty;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam int DLO = slice_lo(k, CH_WIDTH);
    localparam int CLO = slice_lo(k, CNT_BITS);

    logic [CNT_BITS-1:0] cnt;

    pe_relay_chan_fifo #(
      .CH_WIDTH   (CH_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (in_valid[k]),
      .pop     (out_ready[k]),
      .run_en  (run_en),
      .drain   (drain),
      .wr_data (in_data[DLO +: CH_WIDTH]),
      .count   (cnt),
      .ready   (in_ready[k]),
      .valid   (out_valid[k]),
      .data    (out_data[DLO +: CH_WIDTH])
    );

    assign occupancy[CLO +: CNT_BITS] = cnt;
    assign chan_empty[k]              = (cnt == '0);
  end

endmodule

// File: tb/tb_pe_relay_fifo.sv
module tb_pe_relay_fifo;

  localparam int NUM_CH  = 2;
  localparam int W       = 130;
  localparam int D       = 4;
  localparam int CB      = 3;
  localparam int CTRL_W  = 2 * NUM_CH + NUM_CH * CB + 1;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  ap_start;
  logic                  flush;
  logic [NUM_CH*W-1:0]   in_data;
  logic [NUM_CH-1:0]     in_valid;
  logic [NUM_CH-1:0]     in_ready;
  logic [NUM_CH*W-1:0]   out_data;
  logic [NUM_CH-1:0]     out_valid;
  logic [NUM_CH-1:0]     out_ready;
  logic [NUM_CH*CB-1:0]  occupancy;
  logic                  flush_done;

  int checks   = 0;
  int failures = 0;

  // Reference model: one FIFO queue per channel plus the operating mode.
  logic [W-1:0] q[NUM_CH][$];
  int           mode = M_IDLE;
  logic [W-1:0] sent_q[NUM_CH][$];
  logic [W-1:0] got_q[NUM_CH][$];

  always #5 clk = ~clk;

  pe_relay_fifo #(
    .NUM_CH     (NUM_CH),
    .CH_WIDTH   (W),
    .FIFO_DEPTH (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ap_start   (ap_start),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .occupancy  (occupancy),
    .flush_done (flush_done)
  );

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1);
  end

  function automatic logic [W-1:0] rand_word();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  function automatic logic m_ready(int k);
    return (mode != M_DRAIN) && (q[k].size() < D);
  endfunction

  function automatic logic m_valid(int k);
    return (mode != M_IDLE) && (q[k].size() != 0);
  endfunction

  function automatic logic m_all_empty();
    logic e;
    e = 1'b1;
    for (int k = 0; k < NUM_CH; k++) if (q[k].size() != 0) e = 1'b0;
    return e;
  endfunction

  function automatic logic [CTRL_W-1:0] exp_ctrl();
    logic [NUM_CH-1:0]    r;
    logic [NUM_CH-1:0]    v;
    logic [NUM_CH*CB-1:0] o;
    logic                 fd;
    for (int k = 0; k < NUM_CH; k++) begin
      r[k]         = m_ready(k);
      v[k]         = m_valid(k);
      o[k*CB +: CB] = CB'(q[k].size());
    end
    fd = (mode == M_DRAIN) && m_all_empty();
    return {r, v, o, fd};
  endfunction

  function automatic logic [NUM_CH*W-1:0] exp_mask();
    logic [NUM_CH*W-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_CH; k++) if (m_valid(k)) m[k*W +: W] = '1;
    return m;
  endfunction

  function automatic logic [NUM_CH*W-1:0] exp_data();
    logic [NUM_CH*W-1:0] d;
    d = '0;
    for (int k = 0; k < NUM_CH; k++) if (m_valid(k)) d[k*W +: W] = q[k][0];
    return d;
  endfunction

  // Advance one clock; the model sees the same inputs the DUT samples.
  task automatic tick();
    logic [NUM_CH-1:0] pf;
    logic [NUM_CH-1:0] pp;
    int                nm;
    for (int k = 0; k < NUM_CH; k++) begin
      pf[k] = in_valid[k] && m_ready(k);
      pp[k] = out_ready[k] && m_valid(k);
    end
    if (mode == M_DRAIN) nm = m_all_empty() ? M_IDLE : M_DRAIN;
    else if (flush)      nm = M_DRAIN;
    else if (ap_start)   nm = M_RUN;
    else                 nm = M_IDLE;
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) q[k].delete();
      mode = M_IDLE;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (pp[k]) void'(q[k].pop_front());
        if (pf[k]) q[k].push_back(in_data[k*W +: W]);
      end
      mode = nm;
    end
    #1;
  endtask

  task automatic drive_quiet();
    flush    = 1'b0;
    in_valid = '0;
    out_ready = '0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    ap_start = 1'b0;
    flush    = 1'b0;
    in_valid = '0;
    out_ready = '0;
    in_data  = '0;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({in_ready, out_valid, occupancy, flush_done} !== {2'b11, 2'b00, 6'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h",
               {in_ready, out_valid, occupancy, flush_done}, {2'b11, 2'b00, 6'd0, 1'b0});
    end
    checks++;
    if ({in_ready, out_valid, occupancy, flush_done} !== exp_ctrl()) begin
      failures++;
      $display("FAIL reset_model got=%h exp=%h", {in_ready, out_valid, occupancy, flush_done}, exp_ctrl());
    end
  endtask

  task automatic test_basic();
    ap_start  = 1'b1;
    out_ready = 2'b01;
    for (int i = 0; i < 6; i++) begin
      if (i >= 1 && i <= 3) begin
        checks++;
        if ({out_valid[0], out_data[W-1:0]} !== {1'b1, W'(i)}) begin
          failures++;
          $display("FAIL basic_seq cyc=%0d got v=%b d=%h exp v=1 d=%0d", i, out_valid[0], out_data[W-1:0], i);
        end
      end
      checks++;
      if ({in_ready, out_valid, occupancy, flush_done} !== exp_ctrl()) begin
        failures++;
        $display("FAIL basic_ctrl cyc=%0d got=%h exp=%h", i, {in_ready, out_valid, occupancy, flush_done}, exp_ctrl());
      end
      in_valid       = (i < 3) ? 2'b01 : 2'b00;
      in_data[W-1:0] = W'(i + 1);
      tick();
    end
    checks++;
    if (occupancy !== '0) begin
      failures++;
      $display("FAIL basic_empty got=%h exp=0", occupancy);
    end
  endtask

  task automatic test_hold_full();
    logic [W-1:0] words[5];
    drive_quiet();
    ap_start = 1'b0;
    sent_q[1].delete();
    got_q[1].delete();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({in_ready[1], out_valid[1]} !== {(i < 4) ? 1'b1 : 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL hold_ready cyc=%0d got rdy=%b vld=%b exp rdy=%b vld=0", i, in_ready[1], out_valid[1], i < 4);
      end
      checks++;
      if ({in_ready, out_valid, occupancy, flush_done} !== exp_ctrl()) begin
        failures++;
        $display("FAIL hold_ctrl cyc=%0d got=%h exp=%h", i, {in_ready, out_valid, occupancy, flush_done}, exp_ctrl());
      end
      if (i < 5) begin
        words[i]           = rand_word();
        in_valid           = 2'b10;
        in_data[W +: W]    = words[i];
      end else begin
        in_valid = 2'b00;
      end
      tick();
    end
    ap_start  = 1'b1;
    out_ready = 2'b10;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ((out_data & exp_mask()) !== (exp_data() & exp_mask())) begin
        failures++;
        $display("FAIL hold_data cyc=%0d got=%h exp=%h", i, out_data, exp_data());
      end
      if (out_valid[1]) got_q[1].push_back(out_data[W +: W]);
      tick();
    end
    checks++;
    if (got_q[1].size() != 4) begin
      failures++;
      $display("FAIL hold_count got=%0d exp=4", got_q[1].size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[1][i] !== words[i]) begin
          failures++;
          $display("FAIL hold_order idx=%0d got=%h exp=%h", i, got_q[1][i], words[i]);
        end
      end
    end
  endtask

  task automatic test_independent();
    int pops1;
    pops1     = 0;
    ap_start  = 1'b1;
    out_ready = 2'b10;
    in_valid  = 2'b11;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({in_ready, out_valid, occupancy, flush_done} !== exp_ctrl()) begin
        failures++;
        $display("FAIL indep_ctrl cyc=%0d got=%h exp=%h", i, {in_ready, out_valid, occupancy, flush_done}, exp_ctrl());
      end
      checks++;
      if ((out_data & exp_mask()) !== (exp_data() & exp_mask())) begin
        failures++;
        $display("FAIL indep_data cyc=%0d got=%h exp=%h", i, out_data, exp_data());
      end
      if (out_valid[1]) pops1++;
      in_data = {rand_word(), rand_word()};
      tick();
    end
    checks++;
    if ({pops1, occupancy[CB-1:0], in_ready[0]} !== {32'd9, 3'd4, 1'b0}) begin
      failures++;
      $display("FAIL indep_rate got pops1=%0d occ0=%0d rdy0=%b exp 9 4 0", pops1, occupancy[CB-1:0], in_ready[0]);
    end
    in_valid  = 2'b00;
    out_ready = 2'b11;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (occupancy !== '0) begin
      failures++;
      $display("FAIL indep_drain got=%h exp=0", occupancy);
    end
  endtask

  task automatic test_full_wrap();
    ap_start  = 1'b1;
    out_ready = 2'b00;
    in_valid  = 2'b01;
    for (int i = 0; i < 4; i++) begin
      in_data[W-1:0] = rand_word();
      tick();
    end
    out_ready = 2'b01;
    // At full, in_ready is low, so the first cycle is pop-only; afterwards
    // push and pop coincide and the count holds one below full.
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (occupancy[CB-1:0] !== ((i == 0) ? 3'd4 : 3'd3)) begin
        failures++;
        $display("FAIL wrap_occ cyc=%0d got=%0d exp=%0d", i, occupancy[CB-1:0], (i == 0) ? 4 : 3);
      end
      checks++;
      if ((out_data & exp_mask()) !== (exp_data() & exp_mask())) begin
        failures++;
        $display("FAIL wrap_data cyc=%0d got=%h exp=%h", i, out_data, exp_data());
      end
      in_data[W-1:0] = rand_word();
      tick();
    end
    in_valid = 2'b00;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_flush();
    int pulses;
    drive_quiet();
    ap_start = 1'b0;
    tick();
    for (int k = 0; k < NUM_CH; k++) begin
      sent_q[k].delete();
      got_q[k].delete();
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = (i < 2) ? 2'b11 : 2'b10;
      in_data  = {rand_word(), rand_word()};
      for (int k = 0; k < NUM_CH; k++) if (in_valid[k]) sent_q[k].push_back(in_data[k*W +: W]);
      tick();
    end
    in_valid = 2'b00;
    checks++;
    if ({occupancy, out_valid} !== {3'd3, 3'd2, 2'b00}) begin
      failures++;
      $display("FAIL flush_setup got occ=%h vld=%b exp occ=1a vld=00", occupancy, out_valid);
    end
    flush = 1'b1;
    tick();
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      checks++;
      if ({in_ready, out_valid, occupancy, flush_done} !== exp_ctrl()) begin
        failures++;
        $display("FAIL flush_ctrl cyc=%0d got=%h exp=%h", i, {in_ready, out_valid, occupancy, flush_done}, exp_ctrl());
      end
      if (mode == M_DRAIN) begin
        checks++;
        if (in_ready !== 2'b00) begin
          failures++;
          $display("FAIL flush_inready cyc=%0d got=%b exp=00", i, in_ready);
        end
      end
      if (flush_done === 1'b1) pulses++;
      flush     = (i == 1);
      ap_start  = 1'($urandom_range(0, 1)) & 1'b0;
      out_ready = (i > 20) ? 2'b11 : 2'($urandom());
      for (int k = 0; k < NUM_CH; k++)
        if (out_valid[k] && out_ready[k]) got_q[k].push_back(out_data[k*W +: W]);
      tick();
    end
    flush     = 1'b0;
    out_ready = 2'b00;
    checks++;
    if ({pulses, in_ready, out_valid} !== {32'd1, 2'b11, 2'b00}) begin
      failures++;
      $display("FAIL flush_end got pulses=%0d rdy=%b vld=%b exp 1 11 00", pulses, in_ready, out_valid);
    end
    for (int k = 0; k < NUM_CH; k++) begin
      checks++;
      if (got_q[k] != sent_q[k]) begin
        failures++;
        $display("FAIL flush_words ch=%0d got_n=%0d exp_n=%0d", k, got_q[k].size(), sent_q[k].size());
      end
    end
    // Flush with everything empty.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({flush_done, in_ready} !== {1'b1, 2'b00}) begin
      failures++;
      $display("FAIL flush_empty_pulse got fd=%b rdy=%b exp fd=1 rdy=00", flush_done, in_ready);
    end
    tick();
    checks++;
    if ({flush_done, in_ready} !== {1'b0, 2'b11}) begin
      failures++;
      $display("FAIL flush_empty_after got fd=%b rdy=%b exp fd=0 rdy=11", flush_done, in_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      checks++;
      if ({in_ready, out_valid, occupancy, flush_done} !== exp_ctrl()) begin
        failures++;
        $display("FAIL rand_ctrl cyc=%0d got=%h exp=%h", i, {in_ready, out_valid, occupancy, flush_done}, exp_ctrl());
      end
      checks++;
      if ((out_data & exp_mask()) !== (exp_data() & exp_mask())) begin
        failures++;
        $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, out_data, exp_data());
      end
      reset     = ($urandom_range(0, 96) == 0);
      ap_start  = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = 2'($urandom());
      out_ready = 2'($urandom());
      in_data   = {rand_word(), rand_word()};
      tick();
    end
    reset = 1'b0;
    drive_quiet();
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    ap_start  = 1'b1;
    out_ready = 2'b00;
    in_valid  = 2'b01;
    for (int i = 0; i < 3; i++) begin
      in_data[W-1:0] = rand_word();
      tick();
    end
    in_valid = 2'b00;
    checks++;
    if ({occupancy[CB-1:0], out_valid[0]} !== {3'd3, 1'b1}) begin
      failures++;
      $display("FAIL rstmid_pre got occ0=%0d vld0=%b exp 3 1", occupancy[CB-1:0], out_valid[0]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({in_ready, out_valid, occupancy, flush_done} !== {2'b11, 2'b00, 6'd0, 1'b0}) begin
      failures++;
      $display("FAIL rstmid_post got=%h exp=%h",
               {in_ready, out_valid, occupancy, flush_done}, {2'b11, 2'b00, 6'd0, 1'b0});
    end
    checks++;
    if (mode != M_IDLE || {in_ready, out_valid, occupancy, flush_done} !== exp_ctrl()) begin
      failures++;
      $display("FAIL rstmid_model got=%h exp=%h", {in_ready, out_valid, occupancy, flush_done}, exp_ctrl());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_full();
    test_independent();
    test_full_wrap();
    test_flush();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
